// File: rtl/vx_pending_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vx_pending_tracker_pkg
// Purpose  : Shared types and helpers for the pending-instruction tracker.
//            Provides the drain FSM state encoding and the warp-id width
//            helper used to size every wid field in the tracker slice.
// Contents : drain_state_e, wid_width()
// Revision : 1.0 - initial release
// ============================================================================
package vx_pending_tracker_pkg;

  // Warp-id width: at least one bit, even for a single-warp configuration.
  function automatic int wid_width(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  // Drain (fence) request/response FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RSP  = 2'd2
  } drain_state_e;

endpackage : vx_pending_tracker_pkg
`default_nettype wire

// File: rtl/vx_pending_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_pending_tracker_if
// Purpose  : Handshake bundle between the scheduler/commit side and the
//            pending tracker.
// Signals  : issue_valid/issue_wid/issue_ready  - issue throttle
//            committed_warps                    - per-warp commit pulses
//            drain_req_valid/wid/ready          - drain request
//            drain_rsp_valid/wid/ready          - drain response
// Modports : master - drives issue, commits, drain requests
//            slave  - the tracker itself
// Revision : 1.0 - initial release
// ============================================================================
interface vx_pending_tracker_if
  import vx_pending_tracker_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NW_W      = wid_width(NUM_WARPS)
);

  logic                 issue_valid;
  logic [NW_W-1:0]      issue_wid;
  logic                 issue_ready;
  logic [NUM_WARPS-1:0] committed_warps;
  logic                 drain_req_valid;
  logic [NW_W-1:0]      drain_req_wid;
  logic                 drain_req_ready;
  logic                 drain_rsp_valid;
  logic [NW_W-1:0]      drain_rsp_wid;
  logic                 drain_rsp_ready;

  modport master (
    output issue_valid, issue_wid, committed_warps,
    output drain_req_valid, drain_req_wid, drain_rsp_ready,
    input  issue_ready, drain_req_ready, drain_rsp_valid, drain_rsp_wid
  );

  modport slave (
    input  issue_valid, issue_wid, committed_warps,
    input  drain_req_valid, drain_req_wid, drain_rsp_ready,
    output issue_ready, drain_req_ready, drain_rsp_valid, drain_rsp_wid
  );

endinterface : vx_pending_tracker_if
`default_nettype wire

// File: rtl/vx_pending_tracker_ctr.sv
`default_nettype none
// ============================================================================
// Module   : vx_pending_ctr
// Purpose  : Single-warp in-flight instruction counter. Counts up on inc,
//            down on dec, holds when both or neither are set. Saturates at
//            both ends; a dec against an empty counter is flagged.
// Ports    : clk, reset_n     - clock, async active-low reset
//            inc, dec         - up / down requests for this cycle
//            count            - registered count
//            full, zero       - count at max / at zero
//            underflow        - combinational strobe: dec-only while zero
// Revision : 1.0 - initial release
// ============================================================================
module vx_pending_ctr #(
  parameter int CTR_W = 4
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             inc,
  input  wire logic             dec,
  output logic      [CTR_W-1:0] count,
  output logic                  full,
  output logic                  zero,
  output logic                  underflow
);

  localparam logic [CTR_W-1:0] CNT_MAX = '1;

  logic [CTR_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && !dec && (r_count != CNT_MAX)) begin
      r_count <= r_count + CTR_W'(1);
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - CTR_W'(1);
    end
  end

  assign count     = r_count;
  assign full      = (r_count == CNT_MAX);
  assign zero      = (r_count == '0);
  // A simultaneous inc cancels the dec, so only a lone dec can underflow.
  assign underflow = dec && !inc && (r_count == '0);

endmodule : vx_pending_ctr
`default_nettype wire

// File: rtl/vx_pending_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vx_pending_tracker
// Purpose  : Scheduler-side tracker of in-flight instructions per warp.
//            +1 per issue fire, -1 per committed-warp pulse. Throttles issue
//            to full warps and serves single-outstanding drain requests that
//            respond once the requested warp has nothing in flight.
// Ports    : clk, reset_n     - clock, async active-low reset
//            bus (slave)      - issue / commit / drain handshakes
//            pending          - per warp: count != 0
//            full             - per warp: count at maximum
//            pending_total    - sum of all counts
//            underflow_err    - sticky: commit seen against an empty warp
// Revision : 1.0 - initial release
// ============================================================================
module vx_pending_tracker
  import vx_pending_tracker_pkg::*;
#(
  parameter  int NUM_WARPS = 4,
  parameter  int CTR_W     = 4,
  localparam int NW_W      = wid_width(NUM_WARPS),
  localparam int TOT_W     = CTR_W + NW_W
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  vx_pending_tracker_if.slave       bus,
  output logic      [NUM_WARPS-1:0] pending,
  output logic      [NUM_WARPS-1:0] full,
  output logic      [TOT_W-1:0]     pending_total,
  output logic                      underflow_err
);

  // Full wid decode range; ids beyond NUM_WARPS map to "not full, empty".
  localparam int WID_SPAN = 1 << NW_W;

  drain_state_e     r_state;
  drain_state_e     w_state_next;
  logic [NW_W-1:0]  r_cap_wid;
  logic             r_underflow_err;

  logic [CTR_W-1:0]     w_count [NUM_WARPS];
  logic [NUM_WARPS-1:0] w_full;
  logic [NUM_WARPS-1:0] w_zero;
  logic [NUM_WARPS-1:0] w_underflow;
  logic [WID_SPAN-1:0]  w_full_pad;
  logic [WID_SPAN-1:0]  w_zero_pad;
  logic                 w_issue_ready;
  logic                 w_issue_fire;
  logic                 w_req_fire;
  logic [TOT_W-1:0]     w_total;

  // --------------------------------------------------------------------------
  // Issue throttle: depends only on registered state, so a commit arriving
  // in the same cycle never unblocks a full warp until the next cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_full_pad                = '0;
    w_full_pad[NUM_WARPS-1:0] = w_full;
    w_zero_pad                = '1;
    w_zero_pad[NUM_WARPS-1:0] = w_zero;
  end

  assign w_issue_ready = !w_full_pad[bus.issue_wid] &&
                         !((r_state == WAIT) && (bus.issue_wid == r_cap_wid));
  assign w_issue_fire  = bus.issue_valid && w_issue_ready;
  assign bus.issue_ready = w_issue_ready;

  // --------------------------------------------------------------------------
  // Per-warp counters
  // --------------------------------------------------------------------------
  generate
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      vx_pending_ctr #(
        .CTR_W (CTR_W)
      ) u_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc       (w_issue_fire && (bus.issue_wid == NW_W'(w))),
        .dec       (bus.committed_warps[w]),
        .count     (w_count[w]),
        .full      (w_full[w]),
        .zero      (w_zero[w]),
        .underflow (w_underflow[w])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow_err <= 1'b0;
    end else if (|w_underflow) begin
      r_underflow_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_total = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_total = w_total + TOT_W'(w_count[w]);
    end
  end

  assign pending       = ~w_zero;
  assign full          = w_full;
  assign pending_total = w_total;
  assign underflow_err = r_underflow_err;

  // --------------------------------------------------------------------------
  // Drain FSM: state register
  // --------------------------------------------------------------------------
  assign w_req_fire = (r_state == IDLE) && bus.drain_req_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cap_wid <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_req_fire) begin
        r_cap_wid <= bus.drain_req_wid;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (bus.drain_req_valid)      w_state_next = WAIT;
      // Looks at the registered count, so the response trails the last
      // commit by one cycle.
      WAIT: if (w_zero_pad[r_cap_wid])    w_state_next = RSP;
      RSP:  if (bus.drain_rsp_ready)      w_state_next = IDLE;
      default:                            w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Drain FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.drain_req_ready = 1'b0;
    bus.drain_rsp_valid = 1'b0;
    bus.drain_rsp_wid   = r_cap_wid;
    case (r_state)
      IDLE:    bus.drain_req_ready = 1'b1;
      RSP:     bus.drain_rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule : vx_pending_tracker
`default_nettype wire

// File: tb/tb_vx_pending_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_pending_tracker
// Purpose  : Directed self-checking bench for vx_pending_tracker
//            (NUM_WARPS=4, CTR_W=4). Inputs change 1ns after the rising
//            edge; outputs are checked between edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_pending_tracker;

  localparam int NUM_WARPS = 4;
  localparam int CTR_W     = 4;
  localparam int NW_W      = 2;
  localparam int TOT_W     = CTR_W + NW_W;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_WARPS-1:0] pending;
  logic [NUM_WARPS-1:0] full;
  logic [TOT_W-1:0]     pending_total;
  logic                 underflow_err;

  int n_checks;
  int n_fail;

  vx_pending_tracker_if #(.NUM_WARPS(NUM_WARPS), .NW_W(NW_W)) bus ();

  vx_pending_tracker #(
    .NUM_WARPS (NUM_WARPS),
    .CTR_W     (CTR_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus.slave),
    .pending       (pending),
    .full          (full),
    .pending_total (pending_total),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_n(input logic [NW_W-1:0] wid, input int n);
    for (int i = 0; i < n; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_wid   = wid;
      cyc();
    end
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.issue_valid     = 1'b0;
    bus.issue_wid       = '0;
    bus.committed_warps = '0;
    bus.drain_req_valid = 1'b0;
    bus.drain_req_wid   = '0;
    bus.drain_rsp_ready = 1'b0;

    // ---- reset state ----
    #3;
    check_eq("rst_pending",   32'(pending), 0);
    check_eq("rst_full",      32'(full), 0);
    check_eq("rst_total",     32'(pending_total), 0);
    check_eq("rst_req_ready", 32'(bus.drain_req_ready), 1);
    check_eq("rst_rsp_valid", 32'(bus.drain_rsp_valid), 0);
    check_eq("rst_rsp_wid",   32'(bus.drain_rsp_wid), 0);
    check_eq("rst_underflow", 32'(underflow_err), 0);
    #9 reset_n = 1'b1;
    cyc();
    cyc();

    // ---- idle: issue allowed for every warp ----
    for (int w = 0; w < NUM_WARPS; w++) begin
      bus.issue_wid = NW_W'(w);
      #1;
      check_eq($sformatf("idle_issue_ready_w%0d", w), 32'(bus.issue_ready), 1);
    end
    check_eq("idle_total", 32'(pending_total), 0);

    // ---- warp 2: three issues, one commit -> 2 ----
    issue_n(2'd2, 3);
    check_eq("w2_total_after_issue", 32'(pending_total), 3);
    bus.committed_warps = 4'b0100;
    cyc();
    bus.committed_warps = 4'b0000;
    check_eq("w2_pending", 32'(pending), 32'b0100);
    check_eq("w2_total",   32'(pending_total), 2);

    // ---- warp 1: fill to 15 ----
    issue_n(2'd1, 15);
    check_eq("w1_full",  32'(full), 32'b0010);
    check_eq("w1_total", 32'(pending_total), 17);
    bus.issue_wid = 2'd1;
    #1;
    check_eq("w1_full_blocks", 32'(bus.issue_ready), 0);
    // Blocked issue with a same-cycle commit: throttle stays asserted this
    // cycle, the commit alone decrements.
    bus.issue_valid     = 1'b1;
    bus.committed_warps = 4'b0010;
    #1;
    check_eq("w1_same_cycle_still_blocked", 32'(bus.issue_ready), 0);
    cyc();
    bus.issue_valid     = 1'b0;
    bus.committed_warps = 4'b0000;
    #1;
    check_eq("w1_total_14",        32'(pending_total), 16);
    check_eq("w1_not_full",        32'(full), 0);
    check_eq("w1_ready_after_dec", 32'(bus.issue_ready), 1);
    // Issue fire and commit in the same cycle cancel out.
    bus.issue_valid     = 1'b1;
    bus.committed_warps = 4'b0010;
    cyc();
    bus.issue_valid     = 1'b0;
    bus.committed_warps = 4'b0000;
    check_eq("w1_inc_dec_hold", 32'(pending_total), 16);
    bus.committed_warps = 4'b0010;
    cyc();
    bus.committed_warps = 4'b0000;
    check_eq("w1_commit_only", 32'(pending_total), 15);

    // ---- underflow on warp 3 ----
    bus.committed_warps = 4'b1000;
    cyc();
    bus.committed_warps = 4'b0000;
    check_eq("uf_set",       32'(underflow_err), 1);
    check_eq("uf_w3_zero",   32'(pending[3]), 0);
    check_eq("uf_total",     32'(pending_total), 15);
    cyc();
    cyc();
    check_eq("uf_sticky",    32'(underflow_err), 1);

    // ---- drain warp 0 with two in flight ----
    issue_n(2'd0, 2);
    check_eq("d0_pending", 32'(pending), 32'b0111);
    check_eq("d0_total",   32'(pending_total), 17);
    bus.drain_req_valid = 1'b1;
    bus.drain_req_wid   = 2'd0;
    #1;
    check_eq("d0_req_ready", 32'(bus.drain_req_ready), 1);
    cyc();
    bus.drain_req_valid = 1'b0;
    bus.issue_valid     = 1'b1;
    bus.issue_wid       = 2'd0;
    #1;
    check_eq("d0_wait_req_ready", 32'(bus.drain_req_ready), 0);
    check_eq("d0_wait_issue_blk", 32'(bus.issue_ready), 0);
    cyc();
    bus.issue_valid = 1'b0;
    check_eq("d0_blocked_no_inc", 32'(pending_total), 17);
    bus.committed_warps = 4'b0001;
    cyc();
    check_eq("d0_after_commit1", 32'(pending_total), 16);
    cyc();
    bus.committed_warps = 4'b0000;
    check_eq("d0_counter_zero",  32'(pending[0]), 0);
    check_eq("d0_rsp_not_yet",   32'(bus.drain_rsp_valid), 0);
    cyc();
    check_eq("d0_rsp_valid", 32'(bus.drain_rsp_valid), 1);
    check_eq("d0_rsp_wid",   32'(bus.drain_rsp_wid), 0);
    bus.issue_wid = 2'd0;
    #1;
    check_eq("d0_rsp_issue_ok", 32'(bus.issue_ready), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq($sformatf("d0_rsp_hold%0d", i), 32'(bus.drain_rsp_valid), 1);
    end
    bus.drain_rsp_ready = 1'b1;
    bus.drain_req_valid = 1'b1;
    bus.drain_req_wid   = 2'd2;
    #1;
    check_eq("d0_accept_no_req", 32'(bus.drain_req_ready), 0);
    cyc();
    bus.drain_rsp_ready = 1'b0;
    bus.drain_req_valid = 1'b0;
    check_eq("d0_idle_rsp_low",  32'(bus.drain_rsp_valid), 0);
    check_eq("d0_idle_req_rdy",  32'(bus.drain_req_ready), 1);

    // ---- drain warp 3 with zero in flight: response at t+2 ----
    bus.drain_req_valid = 1'b1;
    bus.drain_req_wid   = 2'd3;
    cyc();
    bus.drain_req_valid = 1'b0;
    check_eq("d3_t1_no_rsp", 32'(bus.drain_rsp_valid), 0);
    cyc();
    check_eq("d3_t2_rsp",     32'(bus.drain_rsp_valid), 1);
    check_eq("d3_t2_rsp_wid", 32'(bus.drain_rsp_wid), 3);
    bus.drain_rsp_ready = 1'b1;
    cyc();
    bus.drain_rsp_ready = 1'b0;

    // ---- async reset during WAIT on warp 1 (13 in flight) ----
    bus.drain_req_valid = 1'b1;
    bus.drain_req_wid   = 2'd1;
    cyc();
    bus.drain_req_valid = 1'b0;
    check_eq("r_wait_req_ready", 32'(bus.drain_req_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("r_req_ready", 32'(bus.drain_req_ready), 1);
    check_eq("r_rsp_valid", 32'(bus.drain_rsp_valid), 0);
    check_eq("r_total",     32'(pending_total), 0);
    check_eq("r_underflow", 32'(underflow_err), 0);
    #10 reset_n = 1'b1;
    cyc();
    cyc();
    check_eq("post_rst_rsp_valid", 32'(bus.drain_rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_vx_pending_tracker
`default_nettype wire
